// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b LSB first, one bit per clock, and reports
// the difference with unsigned borrow, signed overflow and zero flags.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;
    logic             zero_q;

    logic             a_bit;
    logic             b_bit;
    logic             diff_bit_d;
    logic             bout_d;

    // Operands shift right alongside the result so bit 0 is always the current bit.
    always_comb begin
        a_bit      = a_sh_q[0];
        b_bit      = b_sh_q[0];
        diff_bit_d = a_bit ^ b_bit ^ bin_q;
        bout_d     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            sr_q       <= '0;
            cnt_q      <= '0;
            bin_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        bin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q   <= {diff_bit_d, sr_q[WIDTH-1:1]};
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    bin_q  <= bout_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    diff_q     <= sr_q;
                    borrow_q   <= bin_q;
                    overflow_q <= (a_msb_q != b_msb_q) && (sr_q[WIDTH-1] != a_msb_q);
                    zero_q     <= (sr_q == '0);
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): arithmetic reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is a countdown of W+2 cycles whose result is plain arithmetic.
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_age  = 0;
    logic [W-1:0] m_diff = '0;
    bit           m_borrow = 1'b0;
    bit           m_ovf  = 1'b0;
    bit           m_zero = 1'b0;
    logic [W-1:0] p_diff;
    bit           p_borrow;
    bit           p_ovf;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            m_busy = 1'b0; m_done = 1'b0; m_age = 0;
            m_diff = '0; m_borrow = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_age++;
                if (m_age == W + 1) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_diff   = p_diff;
                    m_borrow = p_borrow;
                    m_ovf    = p_ovf;
                    m_zero   = (p_diff == 0);
                end
            end else if (start === 1'b1) begin
                int sa;
                int sb;
                int sd;
                m_busy   = 1'b1;
                m_age    = 0;
                p_diff   = W'(int'(a) - int'(b));
                p_borrow = (a < b);
                sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
                sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
                sd = sa - sb;
                p_ovf = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     32'(busy),     32'(m_busy));
            chk("done",     32'(done),     32'(m_done));
            chk("diff",     32'(diff),     32'(m_diff));
            chk("borrow",   32'(borrow),   32'(m_borrow));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("zero",     32'(zero),     32'(m_zero));
        end
    end

    // Issue one operation, scramble the inputs afterwards, and check latency and literal result.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input bit eb, input bit eo, input bit ez,
                          input string name);
        int lat;
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"},  32'(lat),      32'(W + 2));
        chk({name, "_diff"},     32'(diff),     32'(ed));
        chk({name, "_borrow"},   32'(borrow),   32'(eb));
        chk({name, "_overflow"}, 32'(overflow), 32'(eo));
        chk({name, "_zero"},     32'(zero),     32'(ez));
    endtask

    initial begin
        int dones;
        int gap;
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'h01;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_flags", 32'({borrow, overflow, zero}), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_start_ignored", 32'(busy), 32'd0);

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0, "v5A_23");
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, "v10_20");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, "v80_01");
        run_op(8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1, "v33_33");
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, "v00_FF");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, "v7F_FF");
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, "vFF_00");
        @(negedge clk);

        // Start while busy is ignored.
        start = 1'b1; a = 8'h05; b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                chk("busy_ignore_diff", 32'(diff), 32'h02);
            end
        end
        chk("busy_ignore_dones", 32'(dones), 32'd1);

        // Reset mid-operation aborts it.
        start = 1'b1; a = 8'h20; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_outs", 32'({diff, borrow, overflow, zero}), 32'd0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0, "v09_04");

        // Back-to-back: second start in the done cycle.
        run_op(8'h44, 8'h11, 8'h33, 1'b0, 1'b0, 1'b0, "b2b_first");
        start = 1'b1; a = 8'h01; b = 8'h02;
        gap = 0;
        @(negedge clk);
        start = 1'b0;
        gap = 1;
        while (done !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", 32'(gap), 32'(W + 2));
        chk("b2b_diff", 32'(diff), 32'hFF);
        chk("b2b_borrow", 32'(borrow), 32'd1);

        // Pseudo-random operands, checked by the model only.
        for (int i = 0; i < 20; i++) begin
            start = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            start = 1'b0; a = W'($urandom); b = W'($urandom);
            repeat (W + 2 + (i % 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled on a rising edge, accepted only when busy==0.
REQ-005 a  input  WIDTH  minuend; sampled on the accepting edge only.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepting edge only.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse; result outputs are valid from this cycle.
REQ-009 diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 borrow  output  1  unsigned borrow out (a<b).
REQ-011 overflow  output  1  two's-complement signed overflow of a-b.
REQ-012 zero  output  1  high when diff==0.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, FINISH.
REQ-014 IDLE: start==1 -> latch a, b; clear borrow chain and bit counter; go to SHIFT; start==0 -> stay.
REQ-015 SHIFT SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles, then go to FINISH.
REQ-016 Per-bit rule: d = ai ^ bi ^ bin; bout = (~ai & bi) | (~(ai ^ bi) & bin); bin of bit 0 = 0.
REQ-017 The partial result SHALL shift right each SHIFT cycle with d inserted at the MSB; after WIDTH cycles the shift register holds the full difference.
REQ-018 FINISH: diff, borrow, overflow and zero SHALL be updated from the completed operation; done=1 for this one cycle; next state IDLE.
REQ-019 borrow SHALL equal the final bout; overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]); zero = (diff == 0).
REQ-020 busy SHALL be 1 in SHIFT and FINISH, 0 in IDLE.
REQ-021 Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH+1; outputs updated on that same edge.
REQ-022 start while busy==1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-023 start in the cycle following done (IDLE) SHALL be accepted; back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-024 diff, borrow, overflow and zero SHALL hold their values between done pulses and change only in FINISH.
REQ-025 Changes on a or b after the accepting edge SHALL NOT affect the result.

Reset
REQ-026 When rst_n==0 at a rising edge: state=IDLE; busy=0, done=0, diff=0, borrow=0, overflow=0, zero=0; internal operand, shift and counter registers cleared.
REQ-027 Reset during SHIFT or FINISH SHALL abort the operation, with no done pulse and outputs forced to reset values.
REQ-028 start asserted while rst_n==0 SHALL be ignored.

Verification (WIDTH=8)
REQ-029 a=0x5A, b=0x23, start pulse -> done 10 cycles later; diff=0x37, borrow=0, overflow=0, zero=0.
REQ-030 a=0x10, b=0x20 -> diff=0xF0, borrow=1, overflow=0, zero=0.
REQ-031 a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1; a=0x33, b=0x33 -> diff=0x00, zero=1, borrow=0.
REQ-032 Start 0x05-0x03; pulse start with 0xFF-0x00 at cycle 3 while busy -> single done, diff=0x02; second request produces no done.
REQ-033 rst_n low for 1 cycle at SHIFT cycle 4 -> no done, all outputs 0; new start 0x09-0x04 -> diff=0x05 after 10 cycles.
REQ-034 Two back-to-back operations, second start in the cycle after done -> two done pulses 10 cycles apart with correct independent results.
